x2m_ff: RTL

X2M_FF -- requirements
Module: x2m_ff

---
 rtl/x2m_ff.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/x2m_ff.sv
`default_nettype none
// ============================================================================
// Module      : x2m_ff
// Description : Execute-to-Memory pipeline register. Supports stall (hold),
//               flush (bubble insert) and a RUN/HALT/HALTED retirement FSM
//               with a sticky haltedM flag.
//               Optional stall/bubble performance counters are built when
//               the macro X2M_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module x2m_ff (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResX,
  input  logic [15:0] wrtDataX,
  input  logic [15:0] incPCX,
  input  logic        memWrtX,
  input  logic        readEnX,
  input  logic        regWrtX,
  input  logic        haltX,
  input  logic        validX,
  input  logic [1:0]  wbDataSelX,
  input  logic [2:0]  wrtRegX,
  input  logic        stallM,
  input  logic        flushX,
  output logic [15:0] aluResM,
  output logic [15:0] wrtDataM,
  output logic [15:0] incPCM,
  output logic        memWrtM,
  output logic        readEnM,
  output logic        regWrtM,
  output logic        haltM,
  output logic        validM,
  output logic [1:0]  wbDataSelM,
  output logic [2:0]  wrtRegM,
`ifdef X2M_PERF_CNT_EN
  output logic [15:0] stallCnt,
  output logic [15:0] bubbleCnt,
`endif
  output logic        haltedM
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    HALTED = 2'd2
  } state_e;

  // One pipeline entry; an all-zero entry is a bubble.
  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] wdata;
    logic [15:0] pc;
    logic        mem_wrt;
    logic        read_en;
    logic        reg_wrt;
    logic        halt;
    logic        valid;
    logic [1:0]  wb_sel;
    logic [2:0]  wrt_reg;
  } entry_t;

  state_e state_q, state_d;
  entry_t entry_q, entry_d;
  logic   halted_q;

  // Next-state and next-entry selection; hold is the default action.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    case (state_q)
      RUN: begin
        if (stallM) begin
          entry_d = entry_q;
        end else if (flushX || !validX) begin
          // Invalid or squashed entries become bubbles so that no control
          // bit can ever be set alongside validM=0.
          entry_d = '0;
        end else begin
          entry_d = '{alu:     aluResX,
                      wdata:   wrtDataX,
                      pc:      incPCX,
                      mem_wrt: memWrtX,
                      read_en: readEnX,
                      reg_wrt: regWrtX,
                      halt:    haltX,
                      valid:   1'b1,
                      wb_sel:  wbDataSelX,
                      wrt_reg: wrtRegX};
          if (haltX) state_d = HALT;
        end
      end
      HALT: begin
        // Halt entry sits on the outputs until M is free, then retires.
        if (!stallM) begin
          entry_d = '0;
          state_d = HALTED;
        end
      end
      HALTED: begin
        entry_d = '0;
      end
      default: begin
        entry_d = '0;
        state_d = RUN;
      end
    endcase
  end

  // State, entry and sticky halted flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      entry_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign aluResM    = entry_q.alu;
  assign wrtDataM   = entry_q.wdata;
  assign incPCM     = entry_q.pc;
  assign memWrtM    = entry_q.mem_wrt;
  assign readEnM    = entry_q.read_en;
  assign regWrtM    = entry_q.reg_wrt;
  assign haltM      = entry_q.halt;
  assign validM     = entry_q.valid;
  assign wbDataSelM = entry_q.wb_sel;
  assign wrtRegM    = entry_q.wrt_reg;
  assign haltedM    = halted_q;

`ifdef X2M_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] bubble_cnt_q;
  logic        stall_cnt_en;
  logic        bubble_cnt_en;

  assign stall_cnt_en  = stallM && (state_q != HALTED);
  assign bubble_cnt_en = (state_q == RUN) && !stallM && (flushX || !validX);

  // Saturating counters for stall cycles and bubbles inserted while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_cnt_en && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bubble_cnt_en && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign stallCnt  = stall_cnt_q;
  assign bubbleCnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
